// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch unit.
// A two-state request/wait machine issues one word read at a time. Returned
// words go to the decode-facing output register, or to a one-entry skid
// buffer when decode is stalled. Redirects restart fetch at a new address.
// A response that was already in flight when the redirect arrived is marked
// for dropping so that it never reaches decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Architectural state
  logic [0:0]  state_r;
  logic [31:0] fetch_pc_r;
  logic        req_r;
  logic        drop_r;
  logic        skid_full_r;
  logic [31:0] skid_data_r;
  logic [31:0] skid_pc_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_insn_r;
  logic        out_valid_r;

  // Next-state values
  logic [0:0]  state_s;
  logic [31:0] fetch_pc_s;
  logic        req_s;
  logic        drop_s;
  logic        skid_full_s;
  logic [31:0] skid_data_s;
  logic [31:0] skid_pc_s;
  logic [31:0] out_pc_s;
  logic [31:0] out_insn_s;
  logic        out_valid_s;

  // Decoded per-cycle events
  logic        resp_s;
  logic        usable_s;
  logic [31:0] target_s;

  // Next-state computation for the FSM, fetch address, drop flag, skid and output register
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    drop_s      = drop_r;
    skid_full_s = skid_full_r;
    skid_data_s = skid_data_r;
    skid_pc_s   = skid_pc_r;
    out_pc_s    = out_pc_r;
    out_insn_s  = out_insn_r;
    out_valid_s = out_valid_r;

    // Only a response while waiting counts; rvalid in REQ is a protocol error and is ignored.
    resp_s   = (state_r == S_WAIT) && imem_rvalid;
    // A response is consumed only when it is not stale and no redirect overrides it.
    usable_s = resp_s && !drop_r && !redirect;
    // The low address bits of the target are forced to zero.
    target_s = redirect_pc & 32'hFFFF_FFFC;

    // Transitions are the same with or without a redirect: a request that was
    // issued still moves us to WAIT, and a response still ends the wait.
    case (state_r)
      S_REQ: begin
        if (req_r) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_s = S_REQ;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: begin
        state_s = S_REQ;
      end
    endcase

    // Drop flag: armed when a redirect leaves a request in flight, cleared when
    // the in-flight response (stale or not) arrives.
    if (redirect) begin
      if (resp_s) begin
        drop_s = 1'b0;
      end else if ((state_r == S_WAIT) || req_r) begin
        drop_s = 1'b1;
      end else begin
        drop_s = drop_r;
      end
    end else if (resp_s) begin
      drop_s = 1'b0;
    end else begin
      drop_s = drop_r;
    end

    // Fetch address: redirect target wins, otherwise step past each accepted word.
    if (redirect) begin
      fetch_pc_s = target_s;
    end else if (usable_s) begin
      fetch_pc_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end

    // Skid and output register. A redirect empties the skid but leaves the
    // output register to the ordinary stall rules (delay-slot instruction).
    if (redirect) begin
      skid_full_s = 1'b0;
      if (!stall) begin
        out_insn_s  = 32'h0000_0000;
        out_valid_s = 1'b0;
      end else begin
        out_insn_s  = out_insn_r;
        out_valid_s = out_valid_r;
      end
    end else if (!stall) begin
      if (skid_full_r) begin
        out_pc_s    = skid_pc_r;
        out_insn_s  = skid_data_r;
        out_valid_s = 1'b1;
        if (usable_s) begin
          skid_full_s = 1'b1;
          skid_data_s = imem_rdata;
          skid_pc_s   = fetch_pc_r;
        end else begin
          skid_full_s = 1'b0;
        end
      end else if (usable_s) begin
        out_pc_s    = fetch_pc_r;
        out_insn_s  = imem_rdata;
        out_valid_s = 1'b1;
      end else begin
        out_insn_s  = 32'h0000_0000;
        out_valid_s = 1'b0;
      end
    end else begin
      if (usable_s) begin
        skid_full_s = 1'b1;
        skid_data_s = imem_rdata;
        skid_pc_s   = fetch_pc_r;
      end else begin
        skid_full_s = skid_full_r;
      end
    end

    // A request goes out in every REQ cycle unless the skid is holding a word.
    req_s = (state_s == S_REQ) && !skid_full_s;
  end

  // State registers with synchronous reset; the memory shares this reset and
  // forgets any outstanding request, so no drop is needed across reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_REQ;
      fetch_pc_r  <= RESET_PC;
      req_r       <= 1'b0;
      drop_r      <= 1'b0;
      skid_full_r <= 1'b0;
      skid_data_r <= 32'h0000_0000;
      skid_pc_r   <= 32'h0000_0000;
      out_pc_r    <= 32'h0000_0000;
      out_insn_r  <= 32'h0000_0000;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      req_r       <= req_s;
      drop_r      <= drop_s;
      skid_full_r <= skid_full_s;
      skid_data_r <= skid_data_s;
      skid_pc_r   <= skid_pc_s;
      out_pc_r    <= out_pc_s;
      out_insn_r  <= out_insn_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = req_r ? fetch_pc_r : 32'h0000_0000;
  assign pc         = out_pc_r;
  assign insn       = out_insn_r;
  assign insn_valid = out_valid_r;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h80020000, first instruction address after reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  read request to instruction memory, valid for one cycle.
REQ-005 imem_addr  output  32  word-aligned read address, valid while imem_req=1.
REQ-006 imem_rvalid  input  1  read data valid; at most one request outstanding.
REQ-007 imem_rdata  input  32  instruction word, valid while imem_rvalid=1.
REQ-008 stall  input  1  decode cannot accept; output register holds.
REQ-009 redirect  input  1  branch taken or jump; restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 00.
REQ-011 pc  output  32  address of insn presented to decode.
REQ-012 insn  output  32  instruction to decode; 32'h0 (NOP) whenever insn_valid=0.
REQ-013 insn_valid  output  1  insn/pc hold a real fetched instruction.

Function
REQ-014 The block SHALL hold fetch_pc, a 2-state FSM {REQ, WAIT}, a 1-entry skid buffer (data, pc, full flag), a drop flag, and the output register (pc, insn, insn_valid).
REQ-015 In REQ the block SHALL drive imem_req=1, imem_addr=fetch_pc, then go to WAIT, except when the skid buffer is full, in which case it SHALL stay in REQ with imem_req=0.
REQ-016 In WAIT imem_req SHALL be 0, and the block SHALL stay in WAIT until imem_rvalid=1, then return to REQ.
REQ-017 A response with drop=0 SHALL advance fetch_pc by 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-018 The block SHALL load a response with drop=0 into the output register when stall=0, and into the skid buffer when stall=1.
REQ-019 When stall=0 and the skid buffer is full, the skid contents SHALL move to the output register and the skid SHALL clear, with the skid taking priority over a concurrent response (the response goes to the skid).
REQ-020 When stall=0 and there is neither a skid entry nor a usable response, the output register SHALL load insn=0, insn_valid=0, and leave pc unchanged.
REQ-021 When stall=1, pc, insn and insn_valid SHALL hold their values.
REQ-022 Best-case throughput SHALL be one instruction per two cycles (REQ, WAIT with 1-cycle memory), and latency from imem_rvalid to insn_valid SHALL be one cycle.
REQ-023 When redirect=1, the block SHALL set fetch_pc to {redirect_pc[31:2],2'b00} and clear the skid buffer.
REQ-024 A redirect SHALL NOT flush the output register, so its held instruction (the delay slot) proceeds under normal stall rules.
REQ-025 A redirect in WAIT without imem_rvalid, or in REQ (the request to the old address is still issued), SHALL set drop=1; the next FSM state is unchanged.
REQ-026 A redirect in WAIT with imem_rvalid=1 in the same cycle SHALL discard that response, leave drop=0, and go to REQ.
REQ-027 A response with drop=1 SHALL be discarded, SHALL clear drop, and SHALL NOT change fetch_pc, the skid buffer or the output register.
REQ-028 Redirect SHALL take priority over every action except reset.
REQ-029 imem_rvalid in REQ is a protocol violation and SHALL be ignored.

Reset
REQ-030 While reset=1 the block SHALL force fetch_pc=RESET_PC, FSM=REQ, drop=0, skid empty, pc=0, insn=0, insn_valid=0, imem_req=0.
REQ-031 The first request SHALL issue in the cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request, because instruction memory shares the same reset and drops it.

Verification
REQ-033 Reset release with 1-cycle memory returning 0x20080005, 0x20090007 -> insn_valid pulses: pc=0x80020000 insn=0x20080005, then pc=0x80020004 insn=0x20090007.
REQ-034 stall=1 for 3 cycles while a response 0x01095020 arrives -> output unchanged during stall, word held in skid, no new imem_req; stall drops -> output pc=next address, insn=0x01095020 next cycle, fetching resumes.
REQ-035 redirect=1 with redirect_pc=0x80020103 in WAIT, response 2 cycles later -> response discarded, fetch_pc=0x80020100, next imem_addr=0x80020100, output keeps its delay-slot instruction.
REQ-036 redirect and imem_rvalid in the same cycle -> response discarded, drop stays 0, the next cycle issues a request to the target.
REQ-037 RESET_PC=32'hFFFFFFFC -> first fetch at 0xFFFFFFFC, second at 0x00000000.
REQ-038 reset asserted mid-WAIT with valid output -> next cycle all outputs 0, then a request to RESET_PC.
